exu_pipe1_div: RTL and testbench
================================

Name: exu_pipe1_div

Overview:
- Iterative radix-2 integer divider on issue pipe 1, directly downstream of the pipe-1 register-read/forwarding stage.
- Consumes the pipe-1 operation fields and forwarded operand values. Executes RV64M DIV/DIVU/REM/REMU and the W variants.
- Drives the div EX-stage forward bus, the registered div CDB bus, and the retire-unit completion.
- Holds busy while iterating so issue stalls further pipe-1 divides.

Parameters:
- XLEN, 64, datapath width; the W variants use the low XLEN/2 bits.
- CNT_W, 7, iteration counter width; must hold XLEN.

Ports:
- clk  in  1  clock
- rst_clk  in  1  asynchronous active-low reset
- rtu_global_flush  in  1  kill any in-flight divide
- pipe1_vld  in  1  pipe-1 op valid this cycle
- pipe1_iid  in  5  instruction id
- pipe1_opcode  in  7  major opcode
- pipe1_funct7  in  7  funct7
- pipe1_funct3  in  3  funct3
- pipe1_psrc1_value  in  XLEN  dividend (already forwarded)
- pipe1_psrc2_value  in  XLEN  divisor (already forwarded)
- pipe1_pdst_vld  in  1  destination valid
- pipe1_pdst  in  6  destination physical register
- exu_idu_div_busy  out  1  divider occupied
- exu_idu_rf_div_ex_vld  out  1  EX-stage result valid (forward bus)
- exu_idu_rf_div_ex_preg  out  6  EX-stage destination preg
- exu_idu_rf_div_ex_result  out  XLEN  EX-stage result
- exu_idu_rf_div_cdb_vld  out  1  CDB result valid (ex bus delayed one cycle)
- exu_idu_rf_div_cdb_preg  out  6  CDB preg
- exu_idu_rf_div_cdb_result  out  XLEN  CDB result
- exu_rtu_div_cmplt_vld  out  1  completion to retire unit
- exu_rtu_div_cmplt_iid  out  5  completing iid

Behaviour:
- Reset (rst_clk low, async): state IDLE, counter 0, all outputs 0, all operand/result registers 0.
- Accept condition: pipe1_vld & funct7==0000001 & funct3[2] & opcode in {0110011, 0111011} & state==IDLE & ~rtu_global_flush. All other pipe-1 ops are ignored.
- A qualifying op arriving while the state is not IDLE is dropped. This is an upstream protocol violation; the bench asserts it never happens.
- funct3 decode:
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
  - funct3[0]=1 selects unsigned; funct3[1]=1 selects remainder.
  - opcode 0111011 selects W mode.
- W mode:
  - Operands are bits [31:0], sign-extended (signed ops) or zero-extended (unsigned ops).
  - 32 iterations.
  - Final result is sign-extended from bit 31 for all four W ops.
- Signed ops:
  - Iterate on magnitudes.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - Negation is applied in the DONE cycle.
- States: IDLE, CALC, DONE.
  - IDLE -> CALC on accept. Latch iid, pdst, pdst_vld, funct3, W flag, and magnitudes; counter = 64 (or 32 in W mode).
  - IDLE -> DONE on accept when a special case applies (fast path).
  - CALC: one restoring step per cycle; counter decrements. Counter reaching 1 -> DONE next edge.
  - DONE -> IDLE unconditionally next edge.
  - Any state -> IDLE on rtu_global_flush; outputs are not produced.
- Special cases (fast path):
  - Divisor zero: quotient all ones, remainder = dividend (W: sign-extended a[31:0]).
  - Signed overflow (a = most-negative, b = -1): quotient = a, remainder 0.
- Timing, op valid in cycle T:
  - 64-bit: CALC T+1..T+64, DONE T+65; W: DONE T+33; fast path: DONE T+1.
  - EX outputs are valid in the DONE cycle only.
  - CDB outputs and cmplt are registered and appear in DONE+1 as a 1-cycle pulse.
- exu_idu_rf_div_ex_vld = (state==DONE) & pdst_vld & ~rtu_global_flush. preg and result are driven in DONE and forced to 0 otherwise.
- exu_rtu_div_cmplt_vld pulses in DONE+1 even when pdst_vld=0; cdb_vld pulses only when pdst_vld=1.
- exu_idu_div_busy = (state != IDLE). A new divide may be accepted in DONE+1, concurrently with the previous CDB pulse.
- Flush in the DONE cycle suppresses ex_vld, cdb_vld and cmplt. Flush has no effect on an already-registered CDB pulse beyond clearing it on the next edge.
- Reset mid-operation returns to IDLE immediately; no output pulse.

Test Plan:
- DIV a=100, b=7, pdst=12, iid=3, valid at T -> busy T+1..T+65; ex_vld/preg=12/result=14 in T+65; cdb_vld and cmplt_iid=3 in T+66.
- REM a=-100 (0xFF..9C), b=7 -> result 0xFFFFFFFFFFFFFFFE (-2); DIVU a=0xFFFFFFFFFFFFFFFF, b=2 -> 0x7FFFFFFFFFFFFFFF.
- DIVW a=0x00000000_80000000, b=0x00000000_FFFFFFFF -> fast path, ex_vld at T+1, result 0xFFFFFFFF80000000; REMUW a=0x1_00000007, b=5 -> done T+33, result 2.
- DIV b=0, a=5 -> T+1 result 0xFFFFFFFFFFFFFFFF; REM b=0, a=5 -> result 5; pdst_vld=0 -> cmplt pulses, cdb_vld stays 0.
- Flush at T+20 of a 64-bit divide -> busy low T+21, no ex/cdb/cmplt pulse; next divide accepted at T+21 completes normally.
- Non-div pipe-1 op (funct7=0000000, funct3=100) -> ignored, busy stays 0; async reset during CALC -> all outputs 0 immediately.

Source files
------------

// File: rtl/exu_pipe1_div_if.sv
// Pipe-1 divider bus: issue-side operation fields in, EX/CDB/completion results out.
// The master drives the operation and the slave (the divider) returns results.
interface exu_pipe1_div_if #(
    parameter int XLEN = 64
);
    logic            pipe1_vld;
    logic [4:0]      pipe1_iid;
    logic [6:0]      pipe1_opcode;
    logic [6:0]      pipe1_funct7;
    logic [2:0]      pipe1_funct3;
    logic [XLEN-1:0] pipe1_psrc1_value;
    logic [XLEN-1:0] pipe1_psrc2_value;
    logic            pipe1_pdst_vld;
    logic [5:0]      pipe1_pdst;

    logic            exu_idu_div_busy;
    logic            exu_idu_rf_div_ex_vld;
    logic [5:0]      exu_idu_rf_div_ex_preg;
    logic [XLEN-1:0] exu_idu_rf_div_ex_result;
    logic            exu_idu_rf_div_cdb_vld;
    logic [5:0]      exu_idu_rf_div_cdb_preg;
    logic [XLEN-1:0] exu_idu_rf_div_cdb_result;
    logic            exu_rtu_div_cmplt_vld;
    logic [4:0]      exu_rtu_div_cmplt_iid;

    modport master (
        output pipe1_vld, pipe1_iid, pipe1_opcode, pipe1_funct7, pipe1_funct3,
               pipe1_psrc1_value, pipe1_psrc2_value, pipe1_pdst_vld, pipe1_pdst,
        input  exu_idu_div_busy, exu_idu_rf_div_ex_vld, exu_idu_rf_div_ex_preg,
               exu_idu_rf_div_ex_result, exu_idu_rf_div_cdb_vld, exu_idu_rf_div_cdb_preg,
               exu_idu_rf_div_cdb_result, exu_rtu_div_cmplt_vld, exu_rtu_div_cmplt_iid
    );

    modport slave (
        input  pipe1_vld, pipe1_iid, pipe1_opcode, pipe1_funct7, pipe1_funct3,
               pipe1_psrc1_value, pipe1_psrc2_value, pipe1_pdst_vld, pipe1_pdst,
        output exu_idu_div_busy, exu_idu_rf_div_ex_vld, exu_idu_rf_div_ex_preg,
               exu_idu_rf_div_ex_result, exu_idu_rf_div_cdb_vld, exu_idu_rf_div_cdb_preg,
               exu_idu_rf_div_cdb_result, exu_rtu_div_cmplt_vld, exu_rtu_div_cmplt_iid
    );
endinterface

// File: rtl/exu_pipe1_div.sv
// Iterative radix-2 restoring divider for issue pipe 1 (RV64M DIV/DIVU/REM/REMU and W forms).
// Divide-by-zero and signed overflow bypass the iteration and finish one cycle after accept.
module exu_pipe1_div #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic              clk,
    input  logic              rst_clk,
    input  logic              rtu_global_flush,
    exu_pipe1_div_if.slave    io
);
    localparam int HALF = XLEN / 2;
    localparam logic [XLEN-1:0] X_MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] W_MIN = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [XLEN-1:0]   quo_reg, rem_reg, dvs_reg;
    logic [4:0]        iid_reg;
    logic [5:0]        pdst_reg;
    logic              pdst_vld_reg, rem_sel_reg, w_reg, neg_q_reg, neg_r_reg;
    logic              cdb_vld_reg, cmplt_vld_reg;
    logic [5:0]        cdb_preg_reg;
    logic [XLEN-1:0]   cdb_result_reg;
    logic [4:0]        cmplt_iid_reg;

    // Operand decode
    logic              is_div_op, accept, op_w, op_uns;
    logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag;
    logic              a_neg, b_neg, div_zero, sig_ovf;

    always_comb begin
        is_div_op = io.pipe1_vld && (io.pipe1_funct7 == 7'b0000001) && io.pipe1_funct3[2] &&
                    ((io.pipe1_opcode == 7'b0110011) || (io.pipe1_opcode == 7'b0111011));
        accept    = is_div_op && (state_reg == IDLE) && !rtu_global_flush;
        op_w      = (io.pipe1_opcode == 7'b0111011);
        op_uns    = io.pipe1_funct3[0];
        if (op_w) begin
            a_ext = op_uns ? {{HALF{1'b0}}, io.pipe1_psrc1_value[HALF-1:0]}
                           : {{HALF{io.pipe1_psrc1_value[HALF-1]}}, io.pipe1_psrc1_value[HALF-1:0]};
            b_ext = op_uns ? {{HALF{1'b0}}, io.pipe1_psrc2_value[HALF-1:0]}
                           : {{HALF{io.pipe1_psrc2_value[HALF-1]}}, io.pipe1_psrc2_value[HALF-1:0]};
        end else begin
            a_ext = io.pipe1_psrc1_value;
            b_ext = io.pipe1_psrc2_value;
        end
        a_neg    = !op_uns && a_ext[XLEN-1];
        b_neg    = !op_uns && b_ext[XLEN-1];
        a_mag    = a_neg ? -a_ext : a_ext;
        b_mag    = b_neg ? -b_ext : b_ext;
        div_zero = (b_ext == '0);
        sig_ovf  = !op_uns && (b_ext == '1) && (a_ext == (op_w ? W_MIN : X_MIN));
    end

    // One restoring step; the shifted partial remainder needs XLEN+1 bits for unsigned divisors
    logic [XLEN:0]     r_shift, r_diff;
    logic              step_ge;
    logic [XLEN-1:0]   rem_step, quo_step;

    always_comb begin
        r_shift  = {rem_reg, quo_reg[XLEN-1]};
        r_diff   = r_shift - {1'b0, dvs_reg};
        step_ge  = !r_diff[XLEN];
        rem_step = step_ge ? r_diff[XLEN-1:0] : r_shift[XLEN-1:0];
        quo_step = {quo_reg[XLEN-2:0], step_ge};
    end

    // Sign correction and W-mode sign extension happen in the DONE cycle
    logic [XLEN-1:0]   raw_result, fin_result;

    always_comb begin
        if (rem_sel_reg) raw_result = neg_r_reg ? -rem_reg : rem_reg;
        else             raw_result = neg_q_reg ? -quo_reg : quo_reg;
        fin_result = w_reg ? {{HALF{raw_result[HALF-1]}}, raw_result[HALF-1:0]} : raw_result;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = (div_zero || sig_ovf) ? DONE : CALC;
            CALC:    if (cnt_reg == CNT_W'(1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (rtu_global_flush) state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_clk) begin
        if (!rst_clk) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    always_ff @(posedge clk or negedge rst_clk) begin
        if (!rst_clk) begin
            cnt_reg      <= '0;
            quo_reg      <= '0;
            rem_reg      <= '0;
            dvs_reg      <= '0;
            iid_reg      <= '0;
            pdst_reg     <= '0;
            pdst_vld_reg <= 1'b0;
            rem_sel_reg  <= 1'b0;
            w_reg        <= 1'b0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
        end else if (accept) begin
            iid_reg      <= io.pipe1_iid;
            pdst_reg     <= io.pipe1_pdst;
            pdst_vld_reg <= io.pipe1_pdst_vld;
            rem_sel_reg  <= io.pipe1_funct3[1];
            w_reg        <= op_w;
            cnt_reg      <= op_w ? CNT_W'(HALF) : CNT_W'(XLEN);
            dvs_reg      <= b_mag;
            if (div_zero) begin
                quo_reg   <= '1;
                rem_reg   <= a_ext;
                neg_q_reg <= 1'b0;
                neg_r_reg <= 1'b0;
            end else if (sig_ovf) begin
                quo_reg   <= a_ext;
                rem_reg   <= '0;
                neg_q_reg <= 1'b0;
                neg_r_reg <= 1'b0;
            end else begin
                // W dividends sit in the upper half so 32 shifts consume them completely
                quo_reg   <= op_w ? (a_mag << HALF) : a_mag;
                rem_reg   <= '0;
                neg_q_reg <= a_neg ^ b_neg;
                neg_r_reg <= a_neg;
            end
        end else if (state_reg == CALC) begin
            quo_reg <= quo_step;
            rem_reg <= rem_step;
            cnt_reg <= cnt_reg - CNT_W'(1);
        end
    end

    logic done_ok;
    assign done_ok = (state_reg == DONE) && !rtu_global_flush;

    always_ff @(posedge clk or negedge rst_clk) begin
        if (!rst_clk) begin
            cdb_vld_reg    <= 1'b0;
            cdb_preg_reg   <= '0;
            cdb_result_reg <= '0;
            cmplt_vld_reg  <= 1'b0;
            cmplt_iid_reg  <= '0;
        end else begin
            cdb_vld_reg    <= done_ok && pdst_vld_reg;
            cdb_preg_reg   <= (done_ok && pdst_vld_reg) ? pdst_reg : '0;
            cdb_result_reg <= (done_ok && pdst_vld_reg) ? fin_result : '0;
            cmplt_vld_reg  <= done_ok;
            cmplt_iid_reg  <= done_ok ? iid_reg : '0;
        end
    end

    assign io.exu_idu_div_busy          = (state_reg != IDLE);
    assign io.exu_idu_rf_div_ex_vld     = done_ok && pdst_vld_reg;
    assign io.exu_idu_rf_div_ex_preg    = (state_reg == DONE) ? pdst_reg : '0;
    assign io.exu_idu_rf_div_ex_result  = (state_reg == DONE) ? fin_result : '0;
    assign io.exu_idu_rf_div_cdb_vld    = cdb_vld_reg;
    assign io.exu_idu_rf_div_cdb_preg   = cdb_preg_reg;
    assign io.exu_idu_rf_div_cdb_result = cdb_result_reg;
    assign io.exu_rtu_div_cmplt_vld     = cmplt_vld_reg;
    assign io.exu_rtu_div_cmplt_iid     = cmplt_iid_reg;
endmodule

// File: tb/tb_exu_pipe1_div.sv
// Self-checking bench for exu_pipe1_div: directed cases plus random ops against an arithmetic model.
module tb_exu_pipe1_div;
    logic clk = 1'b0;
    logic rst_clk = 1'b0;
    logic rtu_global_flush = 1'b0;
    int   errors = 0;
    int   checks = 0;

    exu_pipe1_div_if #(.XLEN(64)) io ();

    exu_pipe1_div #(.XLEN(64), .CNT_W(7)) dut (
        .clk              (clk),
        .rst_clk          (rst_clk),
        .rtu_global_flush (rtu_global_flush),
        .io               (io)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain RV64M arithmetic with the architectural special cases
    function automatic logic [63:0] ref_result(input logic w, input logic [2:0] f3,
                                               input logic [63:0] a, input logic [63:0] b);
        logic [31:0] a32, b32, q32, r32, s32;
        logic [63:0] q64, r64;
        int          sa, sb;
        longint      la, lb;
        a32 = a[31:0];
        b32 = b[31:0];
        if (w) begin
            if (b32 == 0) begin q32 = '1; r32 = a32; end
            else if (!f3[0] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin q32 = a32; r32 = 0; end
            else if (f3[0]) begin q32 = a32 / b32; r32 = a32 % b32; end
            else begin sa = a32; sb = b32; q32 = 32'(sa / sb); r32 = 32'(sa % sb); end
            s32 = f3[1] ? r32 : q32;
            return {{32{s32[31]}}, s32};
        end
        if (b == 0) begin q64 = '1; r64 = a; end
        else if (!f3[0] && a == 64'h8000_0000_0000_0000 && b == '1) begin q64 = a; r64 = 0; end
        else if (f3[0]) begin q64 = a / b; r64 = a % b; end
        else begin la = a; lb = b; q64 = 64'(la / lb); r64 = 64'(la % lb); end
        return f3[1] ? r64 : q64;
    endfunction

    function automatic int ref_lat(input logic w, input logic [2:0] f3,
                                   input logic [63:0] a, input logic [63:0] b);
        if (w) begin
            if (b[31:0] == 0) return 1;
            if (!f3[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
            return 33;
        end
        if (b == 0) return 1;
        if (!f3[0] && a == 64'h8000_0000_0000_0000 && b == '1) return 1;
        return 65;
    endfunction

    task automatic drive_op(input logic w, input logic [2:0] f3, input logic [63:0] a,
                            input logic [63:0] b, input logic [4:0] iid, input logic [5:0] pdst,
                            input logic pv);
        io.pipe1_vld         = 1'b1;
        io.pipe1_opcode      = w ? 7'b0111011 : 7'b0110011;
        io.pipe1_funct7      = 7'b0000001;
        io.pipe1_funct3      = f3;
        io.pipe1_psrc1_value = a;
        io.pipe1_psrc2_value = b;
        io.pipe1_iid         = iid;
        io.pipe1_pdst        = pdst;
        io.pipe1_pdst_vld    = pv;
    endtask

    // Caller is positioned at a negedge; the op is sampled by the next posedge (cycle T)
    task automatic do_op(input string tag, input logic w, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] iid, input logic [5:0] pdst,
                         input logic pv);
        logic [63:0] exp_res, ex_res, cdb_res;
        logic [5:0]  ex_preg, cdb_preg;
        logic [4:0]  cm_iid;
        int lat, busy_cnt, ex_cnt, ex_cyc, cdb_cnt, cdb_cyc, cm_cnt, cm_cyc, leak;
        exp_res = ref_result(w, f3, a, b);
        lat     = ref_lat(w, f3, a, b);
        busy_cnt = 0; ex_cnt = 0; ex_cyc = 0; cdb_cnt = 0; cdb_cyc = 0; cm_cnt = 0; cm_cyc = 0; leak = 0;
        ex_res = 0; cdb_res = 0; ex_preg = 0; cdb_preg = 0; cm_iid = 0;
        chk({tag, ":idle_before_issue"}, io.exu_idu_div_busy, 0);
        drive_op(w, f3, a, b, iid, pdst, pv);
        for (int k = 1; k <= lat + 2; k++) begin
            @(negedge clk);
            io.pipe1_vld = 1'b0;
            if (io.exu_idu_div_busy) busy_cnt++;
            if (io.exu_idu_rf_div_ex_vld) begin
                ex_cnt++; ex_cyc = k;
                ex_res = io.exu_idu_rf_div_ex_result; ex_preg = io.exu_idu_rf_div_ex_preg;
            end
            if (k != lat && (io.exu_idu_rf_div_ex_result != 0 || io.exu_idu_rf_div_ex_preg != 0)) leak++;
            if (io.exu_idu_rf_div_cdb_vld) begin
                cdb_cnt++; cdb_cyc = k;
                cdb_res = io.exu_idu_rf_div_cdb_result; cdb_preg = io.exu_idu_rf_div_cdb_preg;
            end
            if (io.exu_rtu_div_cmplt_vld) begin
                cm_cnt++; cm_cyc = k; cm_iid = io.exu_rtu_div_cmplt_iid;
            end
        end
        chk({tag, ":busy_cycles"}, busy_cnt, lat);
        chk({tag, ":ex_pulses"}, ex_cnt, pv ? 1 : 0);
        chk({tag, ":ex_cycle"}, ex_cyc, pv ? lat : 0);
        chk({tag, ":ex_result"}, ex_res, pv ? exp_res : 64'd0);
        chk({tag, ":ex_preg"}, ex_preg, pv ? pdst : 6'd0);
        chk({tag, ":ex_zero_outside_done"}, leak, 0);
        chk({tag, ":cdb_pulses"}, cdb_cnt, pv ? 1 : 0);
        chk({tag, ":cdb_cycle"}, cdb_cyc, pv ? lat + 1 : 0);
        chk({tag, ":cdb_result"}, cdb_res, pv ? exp_res : 64'd0);
        chk({tag, ":cdb_preg"}, cdb_preg, pv ? pdst : 6'd0);
        chk({tag, ":cmplt_pulses"}, cm_cnt, 1);
        chk({tag, ":cmplt_cycle"}, cm_cyc, lat + 1);
        chk({tag, ":cmplt_iid"}, cm_iid, iid);
        $display("op %s w=%0d f3=%0b a=%h b=%h -> exp=%h lat=%0d", tag, w, f3, a, b, exp_res, lat);
    endtask

    initial begin
        logic [63:0] ra, rb;
        logic [2:0]  rf3;
        logic [1:0]  rsel;
        logic        rw;
        int          pulses;

        io.pipe1_vld = 0; io.pipe1_iid = 0; io.pipe1_opcode = 0; io.pipe1_funct7 = 0;
        io.pipe1_funct3 = 0; io.pipe1_psrc1_value = 0; io.pipe1_psrc2_value = 0;
        io.pipe1_pdst_vld = 0; io.pipe1_pdst = 0;

        repeat (2) @(negedge clk);
        chk("reset:busy", io.exu_idu_div_busy, 0);
        chk("reset:ex_vld", io.exu_idu_rf_div_ex_vld, 0);
        chk("reset:ex_result", io.exu_idu_rf_div_ex_result, 0);
        chk("reset:cdb_vld", io.exu_idu_rf_div_cdb_vld, 0);
        chk("reset:cmplt_vld", io.exu_rtu_div_cmplt_vld, 0);
        rst_clk = 1'b1;
        @(negedge clk);

        do_op("div_100_7", 0, 3'b100, 64'd100, 64'd7, 5'd3, 6'd12, 1);
        do_op("rem_m100_7", 0, 3'b110, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd4, 6'd13, 1);
        do_op("divu_max_2", 0, 3'b101, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd5, 6'd14, 1);
        do_op("divw_ovf", 1, 3'b100, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd6, 6'd15, 1);
        do_op("remuw_7_5", 1, 3'b111, 64'h0000_0001_0000_0007, 64'd5, 5'd7, 6'd16, 1);
        do_op("div_by0", 0, 3'b100, 64'd5, 64'd0, 5'd8, 6'd17, 1);
        do_op("rem_by0", 0, 3'b110, 64'd5, 64'd0, 5'd9, 6'd18, 1);
        do_op("div_ovf64", 0, 3'b100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd10, 6'd19, 1);
        do_op("remw_neg", 1, 3'b110, 64'h1234_5678_FFFF_FF9C, 64'hDEAD_0000_0000_0007, 5'd11, 6'd20, 1);
        do_op("divuw_by0", 1, 3'b101, 64'd9, 64'hFFFF_FFFF_0000_0000, 5'd12, 6'd21, 0);
        do_op("div_nodst", 0, 3'b100, 64'd1000, 64'd33, 5'd13, 6'd22, 0);

        // Non-divide pipe-1 op is ignored
        io.pipe1_vld = 1; io.pipe1_opcode = 7'b0110011; io.pipe1_funct7 = 7'b0000000;
        io.pipe1_funct3 = 3'b100; io.pipe1_psrc2_value = 64'd3; io.pipe1_psrc1_value = 64'd9;
        @(negedge clk);
        io.pipe1_vld = 0;
        chk("nondiv:busy", io.exu_idu_div_busy, 0);
        @(negedge clk);
        chk("nondiv:cmplt", io.exu_rtu_div_cmplt_vld, 0);
        $display("op nondiv ignored busy=%0d", io.exu_idu_div_busy);

        // Flush at T+20 of a 64-bit divide; next divide issued in T+21
        drive_op(0, 3'b100, 64'd12345, 64'd77, 5'd14, 6'd23, 1);
        pulses = 0;
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            io.pipe1_vld = 0;
            if (io.exu_idu_rf_div_ex_vld || io.exu_idu_rf_div_cdb_vld || io.exu_rtu_div_cmplt_vld) pulses++;
            rtu_global_flush = (k == 20);
        end
        chk("flush:busy_t21", io.exu_idu_div_busy, 0);
        chk("flush:no_pulses", pulses, 0);
        $display("op flush_mid busy=%0d pulses=%0d", io.exu_idu_div_busy, pulses);
        do_op("after_flush", 0, 3'b101, 64'd12345, 64'd77, 5'd15, 6'd24, 1);

        // Flush in the DONE cycle of a fast-path op suppresses every output pulse
        drive_op(0, 3'b100, 64'd5, 64'd0, 5'd16, 6'd25, 1);
        @(negedge clk);
        io.pipe1_vld = 0;
        rtu_global_flush = 1;
        #1;
        chk("flush_done:ex_vld", io.exu_idu_rf_div_ex_vld, 0);
        @(negedge clk);
        rtu_global_flush = 0;
        chk("flush_done:cdb_vld", io.exu_idu_rf_div_cdb_vld, 0);
        chk("flush_done:cmplt_vld", io.exu_rtu_div_cmplt_vld, 0);
        chk("flush_done:busy", io.exu_idu_div_busy, 0);
        $display("op flush_done cdb=%0d cmplt=%0d", io.exu_idu_rf_div_cdb_vld, io.exu_rtu_div_cmplt_vld);

        // Async reset during CALC
        drive_op(0, 3'b100, 64'd999, 64'd3, 5'd17, 6'd26, 1);
        repeat (10) @(negedge clk);
        io.pipe1_vld = 0;
        chk("areset:busy_before", io.exu_idu_div_busy, 1);
        #2 rst_clk = 1'b0;
        #1;
        chk("areset:busy", io.exu_idu_div_busy, 0);
        chk("areset:ex_vld", io.exu_idu_rf_div_ex_vld, 0);
        chk("areset:cdb_vld", io.exu_idu_rf_div_cdb_vld, 0);
        chk("areset:cmplt_vld", io.exu_rtu_div_cmplt_vld, 0);
        $display("op async_reset busy=%0d", io.exu_idu_div_busy);
        @(negedge clk);
        rst_clk = 1'b1;
        @(negedge clk);

        // Random ops with biased divisors to hit zero, -1 and small values
        for (int n = 0; n < 24; n++) begin
            rw   = 1'($urandom_range(0, 1));
            rsel = 2'($urandom_range(0, 3));
            rf3  = {1'b1, rsel};
            ra   = {$urandom, $urandom};
            rb   = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: rb = 64'd0;
                1: rb = 64'hFFFF_FFFF_FFFF_FFFF;
                2: rb = 64'($urandom_range(1, 20));
                3: rb = -64'($urandom_range(1, 20));
                default: ;
            endcase
            if ($urandom_range(0, 5) == 0) ra = rw ? {ra[63:32], 32'h8000_0000} : 64'h8000_0000_0000_0000;
            do_op($sformatf("rand%0d", n), rw, rf3, ra, rb, 5'($urandom_range(0, 31)),
                  6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
